// File: rtl/flipper_bank.sv
// -----------------------------------------------------------------------------
// flipper_bank
//   Bank of NCH independent pinball flipper animators. Each channel
//   synchronises its raw button, debounces it in whole animation frames and
//   drives a four-state motion FSM that swings the flipper angle between a
//   rest angle (ANG_MIN) and a raised angle (ANG_MAX). All debounce and FSM
//   updates happen only on cycles where the frame strobe i_animate is high.
//
// Ports
//   i_clk      system clock (single domain)
//   i_rst      asynchronous, active-high reset
//   i_animate  one-cycle frame strobe
//   i_btn      [NCH]         raw buttons, active-high, asynchronous to i_clk
//   o_angle    [NCH*ANG_W]   channel n angle at [n*ANG_W +: ANG_W]
//   o_state    [2*NCH]       channel n state at [2*n +: 2]
//                            (00 REST, 01 RISING, 10 HELD, 11 FALLING)
//   o_moving   [NCH]         high while RISING or FALLING
//   o_kick     [NCH]         one-cycle pulse after the strobe on which a
//                            rising flipper reaches ANG_MAX
// -----------------------------------------------------------------------------
module flipper_bank #(
  parameter int NCH        = 2,
  parameter int ANG_W      = 8,
  parameter int ANG_MIN    = 20,
  parameter int ANG_MAX    = 70,
  parameter int STEP_UP    = 10,
  parameter int STEP_DN    = 5,
  parameter int DEB_FRAMES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_animate,
  input  logic [NCH-1:0]         i_btn,
  output logic [NCH*ANG_W-1:0]   o_angle,
  output logic [2*NCH-1:0]       o_state,
  output logic [NCH-1:0]         o_moving,
  output logic [NCH-1:0]         o_kick
);

  localparam int CNT_W = $clog2(DEB_FRAMES + 1);
  // ANG_W+1 magnitude bits plus a sign bit, so neither the climb past
  // 2^ANG_W-1 nor the descent below 0 can wrap before saturation.
  localparam int EXT_W = ANG_W + 2;

  localparam logic signed [EXT_W-1:0] S_UP  = EXT_W'(STEP_UP);
  localparam logic signed [EXT_W-1:0] S_DN  = EXT_W'(STEP_DN);
  localparam logic signed [EXT_W-1:0] S_MIN = EXT_W'(ANG_MIN);
  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'(ANG_MAX);

  localparam logic [ANG_W-1:0] ANG_MIN_V = ANG_W'(ANG_MIN);
  localparam logic [ANG_W-1:0] ANG_MAX_V = ANG_W'(ANG_MAX);
  localparam logic [CNT_W-1:0] DEB_V     = CNT_W'(DEB_FRAMES);

  typedef enum logic [1:0] {
    ST_REST    = 2'b00,
    ST_RISING  = 2'b01,
    ST_HELD    = 2'b10,
    ST_FALLING = 2'b11
  } state_t;

  // Step up by STEP_UP, clamped at ANG_MAX.
  function automatic logic [ANG_W-1:0] sat_up(input logic [ANG_W-1:0] ang);
    logic signed [EXT_W-1:0] sum;
    sum = $signed({2'b00, ang}) + S_UP;
    if (sum >= S_MAX) return ANG_MAX_V;
    return sum[ANG_W-1:0];
  endfunction

  // Step down by STEP_DN, clamped at ANG_MIN.
  function automatic logic [ANG_W-1:0] sat_dn(input logic [ANG_W-1:0] ang);
    logic signed [EXT_W-1:0] diff;
    diff = $signed({2'b00, ang}) - S_DN;
    if (diff <= S_MIN) return ANG_MIN_V;
    return diff[ANG_W-1:0];
  endfunction

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic             sync_p0;
    logic             sync_p1;
    logic             deb;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    state_t           state;
    state_t           state_nxt;
    logic [ANG_W-1:0] angle;
    logic [ANG_W-1:0] angle_nxt;
    logic [ANG_W-1:0] ang_up;
    logic [ANG_W-1:0] ang_dn;
    logic             kick;
    logic             kick_nxt;

    // Stage p0/p1: two-flop synchroniser, free-running on every clock so the
    // button level is settled well before the next frame strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
      end else begin
        sync_p0 <= i_btn[n];
        sync_p1 <= sync_p0;
      end
    end

    // Debounce stage: level must disagree for DEB_FRAMES strobes in a row.
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        deb <= 1'b0;
        cnt <= '0;
      end else if (i_animate) begin
        if (sync_p1 == deb) begin
          cnt <= '0;
        end else if (cnt_inc == DEB_V) begin
          deb <= sync_p1;
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end

    // Motion FSM stage. It reads deb as registered before this strobe, so it
    // trails the debouncer by exactly one frame.
    assign ang_up = sat_up(angle);
    assign ang_dn = sat_dn(angle);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state <= ST_REST;
        angle <= ANG_MIN_V;
        kick  <= 1'b0;
      end else begin
        state <= state_nxt;
        angle <= angle_nxt;
        kick  <= kick_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      angle_nxt = angle;
      kick_nxt  = 1'b0;
      if (i_animate) begin
        case (state)
          ST_REST: begin
            if (deb) state_nxt = ST_RISING;
          end
          ST_RISING: begin
            // A direction change costs one frame with no angle step.
            if (!deb) begin
              state_nxt = ST_FALLING;
            end else begin
              angle_nxt = ang_up;
              if (ang_up == ANG_MAX_V) begin
                state_nxt = ST_HELD;
                kick_nxt  = 1'b1;
              end
            end
          end
          ST_HELD: begin
            if (!deb) state_nxt = ST_FALLING;
          end
          ST_FALLING: begin
            if (deb) begin
              state_nxt = ST_RISING;
            end else begin
              angle_nxt = ang_dn;
              if (ang_dn == ANG_MIN_V) state_nxt = ST_REST;
            end
          end
          default: state_nxt = ST_REST;
        endcase
      end
    end

    assign o_angle[n*ANG_W +: ANG_W] = angle;
    assign o_state[2*n +: 2]         = state;
    assign o_moving[n]               = (state == ST_RISING) || (state == ST_FALLING);
    assign o_kick[n]                 = kick;
  end

endmodule

// File: tb/tb_flipper_bank.sv
// -----------------------------------------------------------------------------
// tb_flipper_bank
//   Self-checking bench for flipper_bank at default parameters. A frame-level
//   reference model (debounce counters, motion rules, saturating angles in
//   plain integers) predicts every channel's outputs after each strobe and a
//   few idle cycles later; directed scenarios add hand-derived constants.
// -----------------------------------------------------------------------------
module tb_flipper_bank;

  localparam int NCH     = 2;
  localparam int ANG_W   = 8;
  localparam int ANG_MIN = 20;
  localparam int ANG_MAX = 70;
  localparam int STEP_UP = 10;
  localparam int STEP_DN = 5;
  localparam int DEB     = 2;
  localparam int OW      = NCH*ANG_W + 4*NCH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 animate;
  logic [NCH-1:0]       btn;
  logic [NCH*ANG_W-1:0] o_angle;
  logic [2*NCH-1:0]     o_state;
  logic [NCH-1:0]       o_moving;
  logic [NCH-1:0]       o_kick;

  always #5 clk = ~clk;

  flipper_bank #(
    .NCH(NCH), .ANG_W(ANG_W), .ANG_MIN(ANG_MIN), .ANG_MAX(ANG_MAX),
    .STEP_UP(STEP_UP), .STEP_DN(STEP_DN), .DEB_FRAMES(DEB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_animate(animate), .i_btn(btn),
    .o_angle(o_angle), .o_state(o_state), .o_moving(o_moving), .o_kick(o_kick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model, one entry per channel. State codes: 0 REST, 1 RISING,
  // 2 HELD, 3 FALLING.
  int m_deb[NCH];
  int m_cnt[NCH];
  int m_state[NCH];
  int m_angle[NCH];
  int m_kick[NCH];

  logic [NCH*ANG_W-1:0] obs_angle;
  logic [2*NCH-1:0]     obs_state;
  logic [NCH-1:0]       obs_moving;
  logic [NCH-1:0]       obs_kick;
  logic [OW-1:0]        obs_now;
  logic [OW-1:0]        obs_late;

  function automatic void model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_deb[n] = 0; m_cnt[n] = 0; m_state[n] = 0;
      m_angle[n] = ANG_MIN; m_kick[n] = 0;
    end
  endfunction

  function automatic void model_strobe(input logic [NCH-1:0] lvl);
    for (int n = 0; n < NCH; n++) begin
      int seen;
      int a;
      seen = m_deb[n];
      if (int'(lvl[n]) == m_deb[n]) begin
        m_cnt[n] = 0;
      end else begin
        m_cnt[n] = m_cnt[n] + 1;
        if (m_cnt[n] == DEB) begin
          m_deb[n] = int'(lvl[n]);
          m_cnt[n] = 0;
        end
      end
      m_kick[n] = 0;
      case (m_state[n])
        0: if (seen == 1) m_state[n] = 1;
        1: begin
          if (seen == 0) m_state[n] = 3;
          else begin
            a = m_angle[n] + STEP_UP;
            if (a > ANG_MAX) a = ANG_MAX;
            m_angle[n] = a;
            if (a == ANG_MAX) begin m_state[n] = 2; m_kick[n] = 1; end
          end
        end
        2: if (seen == 0) m_state[n] = 3;
        default: begin
          if (seen == 1) m_state[n] = 1;
          else begin
            a = m_angle[n] - STEP_DN;
            if (a < ANG_MIN) a = ANG_MIN;
            m_angle[n] = a;
            if (a == ANG_MIN) m_state[n] = 0;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [OW-1:0] expected(input bit with_kick);
    logic [NCH*ANG_W-1:0] a;
    logic [2*NCH-1:0]     s;
    logic [NCH-1:0]       mv;
    logic [NCH-1:0]       k;
    for (int n = 0; n < NCH; n++) begin
      a[n*ANG_W +: ANG_W] = ANG_W'(m_angle[n]);
      s[2*n +: 2]         = 2'(m_state[n]);
      mv[n]               = (m_state[n] == 1) || (m_state[n] == 3);
      k[n]                = with_kick && (m_kick[n] != 0);
    end
    return {a, s, mv, k};
  endfunction

  // One animation frame: settle time for the synchroniser, a one-cycle
  // strobe, a sample in the cycle after it, and a sample two idle cycles on.
  task automatic frame();
    repeat (3) @(negedge clk);
    animate = 1'b1;
    model_strobe(btn);
    @(negedge clk);
    animate    = 1'b0;
    obs_angle  = o_angle;
    obs_state  = o_state;
    obs_moving = o_moving;
    obs_kick   = o_kick;
    obs_now    = {o_angle, o_state, o_moving, o_kick};
    repeat (2) @(negedge clk);
    obs_late   = {o_angle, o_state, o_moving, o_kick};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; animate = 1'b0; btn = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_angle, o_state, o_moving, o_kick} !== {8'd20, 8'd20, 4'b0000, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {o_angle, o_state, o_moving, o_kick},
               {8'd20, 8'd20, 4'b0000, 2'b00, 2'b00});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_press();
    int exp_ang[8] = '{20, 20, 20, 30, 40, 50, 60, 70};
    int exp_st[8]  = '{0, 0, 1, 1, 1, 1, 1, 2};
    apply_reset();
    btn = 2'b01;
    for (int i = 0; i < 8; i++) begin
      frame();
      checks++;
      if (obs_now !== expected(1'b1) || obs_late !== expected(1'b0)) begin
        failures++;
        $display("FAIL press_model f%0d got=%h/%h exp=%h/%h", i+1, obs_now, obs_late,
                 expected(1'b1), expected(1'b0));
      end
      checks++;
      if (obs_angle[7:0] !== 8'(exp_ang[i]) || obs_state[1:0] !== 2'(exp_st[i]) ||
          obs_angle[15:8] !== 8'd20 || obs_state[3:2] !== 2'b00 ||
          obs_kick !== ((i == 7) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL press_seq f%0d got ang=%0d st=%0d kick=%b exp ang=%0d st=%0d", i+1,
                 obs_angle[7:0], obs_state[1:0], obs_kick, exp_ang[i], exp_st[i]);
      end
    end
  endtask

  // Continues from HELD left by test_press.
  task automatic test_release();
    int ea;
    int es;
    btn = 2'b00;
    for (int i = 1; i <= 14; i++) begin
      frame();
      if (i < 3)       begin ea = 70; es = 2; end
      else if (i < 13) begin ea = 70 - 5*(i-3); es = 3; end
      else             begin ea = 20; es = 0; end
      checks++;
      if (obs_now !== expected(1'b1) || obs_late !== expected(1'b0) ||
          obs_angle[7:0] !== 8'(ea) || obs_state[1:0] !== 2'(es) ||
          obs_moving[0] !== (es == 3)) begin
        failures++;
        $display("FAIL release f%0d got ang=%0d st=%0d mv=%b exp ang=%0d st=%0d", i,
                 obs_angle[7:0], obs_state[1:0], obs_moving[0], ea, es);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      btn = (i == 1) ? 2'b01 : 2'b00;
      frame();
      checks++;
      if (obs_now !== expected(1'b1) || obs_angle[7:0] !== 8'd20 || obs_state[1:0] !== 2'b00) begin
        failures++;
        $display("FAIL glitch f%0d got ang=%0d st=%0d exp ang=20 st=0", i,
                 obs_angle[7:0], obs_state[1:0]);
      end
    end
  endtask

  task automatic test_reverse();
    int kicks = 0;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      btn = (i <= 4 || i >= 9) ? 2'b01 : 2'b00;
      frame();
      if (obs_kick[0]) kicks++;
      checks++;
      if (obs_now !== expected(1'b1) || obs_late !== expected(1'b0)) begin
        failures++;
        $display("FAIL reverse_model f%0d got=%h exp=%h", i, obs_now, expected(1'b1));
      end
      if (i == 7) begin
        checks++;
        if (obs_state[1:0] !== 2'b11 || obs_angle[7:0] !== 8'd50 || kicks != 0) begin
          failures++;
          $display("FAIL reverse_fall got st=%0d ang=%0d kicks=%0d exp st=3 ang=50 kicks=0",
                   obs_state[1:0], obs_angle[7:0], kicks);
        end
      end
      if (i == 11) begin
        checks++;
        if (obs_state[1:0] !== 2'b01 || obs_angle[7:0] !== 8'd35) begin
          failures++;
          $display("FAIL reverse_rise got st=%0d ang=%0d exp st=1 ang=35",
                   obs_state[1:0], obs_angle[7:0]);
        end
      end
    end
    checks++;
    if (kicks != 1 || obs_angle[7:0] !== 8'd70) begin
      failures++;
      $display("FAIL reverse_kicks got kicks=%0d ang=%0d exp kicks=1 ang=70", kicks, obs_angle[7:0]);
    end
  endtask

  task automatic test_both();
    apply_reset();
    btn = 2'b11;
    for (int i = 1; i <= 9; i++) begin
      frame();
      checks++;
      if (obs_now !== expected(1'b1) || obs_angle[7:0] !== obs_angle[15:8] ||
          obs_state[1:0] !== obs_state[3:2] || obs_kick !== ((i == 8) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL both f%0d got=%h kick=%b exp=%h", i, obs_now, obs_kick, expected(1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    btn = 2'b01;
    for (int i = 1; i <= 5; i++) frame();
    checks++;
    if (obs_angle[7:0] !== 8'd40 || obs_state[1:0] !== 2'b01) begin
      failures++;
      $display("FAIL resetmid_pre got ang=%0d st=%0d exp ang=40 st=1", obs_angle[7:0], obs_state[1:0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_angle, o_state, o_moving, o_kick} !== {8'd20, 8'd20, 4'b0000, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL resetmid_async got=%h exp=%h", {o_angle, o_state, o_moving, o_kick},
               {8'd20, 8'd20, 4'b0000, 2'b00, 2'b00});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 9; i++) begin
      frame();
      checks++;
      if (obs_now !== expected(1'b1) || obs_late !== expected(1'b0) ||
          obs_kick[0] !== (i == 8) || (i >= 8 && obs_angle[7:0] !== 8'd70)) begin
        failures++;
        $display("FAIL resetmid_after f%0d got=%h exp=%h", i, obs_now, expected(1'b1));
      end
    end
  endtask

  task automatic test_random();
    int hold[NCH];
    apply_reset();
    for (int n = 0; n < NCH; n++) hold[n] = 0;
    for (int i = 1; i <= 400; i++) begin
      for (int n = 0; n < NCH; n++) begin
        if (hold[n] == 0) begin
          btn[n]  = 1'($urandom_range(0, 1));
          hold[n] = int'($urandom_range(0, 12));
        end else begin
          hold[n]--;
        end
      end
      frame();
      checks++;
      if (obs_now !== expected(1'b1)) begin
        failures++;
        $display("FAIL random_strobe f%0d got=%h exp=%h", i, obs_now, expected(1'b1));
      end
      checks++;
      if (obs_late !== expected(1'b0)) begin
        failures++;
        $display("FAIL random_idle f%0d got=%h exp=%h", i, obs_late, expected(1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_reverse();
    test_both();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
